// File: rtl/bit_serial_alu_ctrl_if.sv
// ---------------------------------------------------------------------------
// bit_serial_alu_ctrl_if
// Request/result bundle for the bit-serial ALU controller.
//
// Handshake: 'start' is a single-cycle request that the controller takes
// only while idle (busy=0, done=0). A request seen while busy or during the
// done cycle is dropped. 'done' pulses for exactly one cycle when 'result'
// and 'overflow' (and 'zero') carry the finished word. Those outputs then
// stay put until the next accepted request completes.
//
// Signals:
//   start    request, master -> slave
//   opcode   {ainvert, binvert, op[1:0]}, master -> slave
//   a, b     WIDTH-bit operands, master -> slave
//   busy     high while bits are being processed, slave -> master
//   done     one-cycle completion pulse, slave -> master
//   result   WIDTH-bit result word, slave -> master
//   overflow signed overflow for add/subtract, slave -> master
//   zero     result==0 flag, only with BIT_SERIAL_ALU_CTRL_ZERO_FLAG_EN
// ---------------------------------------------------------------------------
interface bit_serial_alu_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             overflow;
`ifdef BIT_SERIAL_ALU_CTRL_ZERO_FLAG_EN
    logic             zero;

    modport master (
        output start, opcode, a, b,
        input  busy, done, result, overflow, zero
    );
    modport slave (
        input  start, opcode, a, b,
        output busy, done, result, overflow, zero
    );
`else
    modport master (
        output start, opcode, a, b,
        input  busy, done, result, overflow
    );
    modport slave (
        input  start, opcode, a, b,
        output busy, done, result, overflow
    );
`endif
endinterface

// File: rtl/bit_serial_alu_ctrl.sv
// ---------------------------------------------------------------------------
// bit_serial_alu_ctrl
// Multi-bit ALU built from one 1-bit slice. The controller latches the
// operands and opcode, then feeds the slice LSB to MSB one bit per clock.
// The carry is kept in a register between cycles. The result word is
// assembled in a shadow register and published on entry to DONE.
//
// Optional feature: define BIT_SERIAL_ALU_CTRL_ZERO_FLAG_EN to add the
// 'zero' output. It is computed serially by OR-accumulating result bits.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   bus        bit_serial_alu_ctrl_if.slave (start/opcode/a/b in,
//              busy/done/result/overflow[/zero] out)
//   dbg_state  current FSM state (IDLE=0, RUN=1, DONE=2)
// ---------------------------------------------------------------------------
module bit_serial_alu_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    bit_serial_alu_ctrl_if.slave  bus,
    output logic [1:0]            dbg_state
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [3:0]       op_q;
    logic             carry_q;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] result_q;
    logic             ovf_q;
    logic             zacc_q;

    logic last, x, y, sum, cout, slt_bit, res_bit, new_bits;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_RUN;
            S_RUN:   if (last)      state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // The 1-bit slice and word assembly
    always_comb begin
        last     = (cnt_q == CW'(WIDTH - 1));
        x        = a_q[cnt_q] ^ op_q[3];
        y        = b_q[cnt_q] ^ op_q[2];
        sum      = x ^ y ^ carry_q;
        cout     = (x & y) | (x & carry_q) | (y & carry_q);
        // Sign of the true difference: MSB sum corrected by the overflow term.
        slt_bit  = sum ^ carry_q ^ cout;
        res_bit  = 1'b0;
        case (op_q[1:0])
            2'b00:   res_bit = x & y;
            2'b01:   res_bit = x | y;
            2'b10:   res_bit = sum;
            default: res_bit = 1'b0;   // SLT: only bit 0 is ever non-zero
        endcase
        shadow_d         = shadow_q;
        shadow_d[cnt_q]  = res_bit;
        new_bits         = res_bit;
        if (op_q[1:0] == 2'b11 && last) begin
            shadow_d[0] = slt_bit;
            new_bits    = slt_bit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            carry_q  <= 1'b0;
            shadow_q <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            zacc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        a_q      <= bus.a;
                        b_q      <= bus.b;
                        op_q     <= bus.opcode;
                        shadow_q <= '0;
                        cnt_q    <= '0;
                        // binvert doubles as carry-in so ~b + 1 forms -b.
                        carry_q  <= bus.opcode[2];
                        zacc_q   <= 1'b0;
                    end
                end
                S_RUN: begin
                    shadow_q <= shadow_d;
                    carry_q  <= cout;
                    zacc_q   <= zacc_q | new_bits;
                    if (last) begin
                        result_q <= shadow_d;
                        ovf_q    <= (op_q[1:0] == 2'b10) & (carry_q ^ cout);
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = (state_q == S_RUN);
    assign bus.done     = (state_q == S_DONE);
    assign bus.result   = result_q;
    assign bus.overflow = ovf_q;
    assign dbg_state    = state_q;

`ifdef BIT_SERIAL_ALU_CTRL_ZERO_FLAG_EN
    logic zero_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            zero_q <= 1'b0;
        end else if (state_q == S_RUN && last) begin
            zero_q <= ~(zacc_q | new_bits);
        end
    end

    assign bus.zero = zero_q;
`endif

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bit_serial_alu_ctrl
// Self-checking bench for bit_serial_alu_ctrl at WIDTH=8. The reference
// model works on whole words with integer arithmetic. Expected words are
// queued per accepted request and checked whenever done is high.
// ---------------------------------------------------------------------------
module tb_bit_serial_alu_ctrl;
    localparam int W = 8;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    // {zero, overflow, result}
    logic [W+1:0] exp_q[$];
    logic [W+1:0] cmp_e;

    bit_serial_alu_ctrl_if #(.WIDTH(W)) bus();

    bit_serial_alu_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model ----------------
    function automatic logic [W+1:0] model(input logic [3:0] op,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [W-1:0] x, y, r;
        int sx, sy, s;
        logic ov;
        x  = op[3] ? ~a : a;
        y  = op[2] ? ~b : b;
        sx = $signed(x);
        sy = $signed(y);
        s  = sx + sy + (op[2] ? 1 : 0);
        ov = 1'b0;
        case (op[1:0])
            2'b00: r = x & y;
            2'b01: r = x | y;
            2'b10: begin
                r  = W'(s);
                ov = (s > (2 ** (W - 1)) - 1) || (s < -(2 ** (W - 1)));
            end
            default: r = (s < 0) ? W'(1) : W'(0);
        endcase
        return {(r == '0), ov, r};
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        if (!rst && bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'(bus.done), 64'd0);
            end else begin
                cmp_e = exp_q.pop_front();
                check("result", 64'(bus.result), 64'(cmp_e[W-1:0]));
                check("overflow", 64'(bus.overflow), 64'(cmp_e[W]));
`ifdef BIT_SERIAL_ALU_CTRL_ZERO_FLAG_EN
                check("zero", 64'(bus.zero), 64'(cmp_e[W+1]));
`endif
            end
        end
    end

    // ---------------- driver tasks ----------------
    // inject: 0 = none, 1..W = extra start in that busy cycle, W+1 = in DONE
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int inject);
        logic [W+1:0] e;
        e = model(op, a, b);
        @(negedge clk);
        bus.start = 1'b1; bus.opcode = op; bus.a = a; bus.b = b;
        exp_q.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 1; i <= W; i++) begin
            check("busy_run", 64'(bus.busy), 64'd1);
            check("done_run", 64'(bus.done), 64'd0);
            if (i == inject) begin
                bus.start  = 1'b1;
                bus.opcode = 4'($urandom_range(0, 15));
                bus.a      = W'($urandom);
                bus.b      = W'($urandom);
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        check("done_pulse", 64'(bus.done), 64'd1);
        check("busy_done", 64'(bus.busy), 64'd0);
        if (inject == W + 1) bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("done_low", 64'(bus.done), 64'd0);
        check("busy_idle", 64'(bus.busy), 64'd0);
        check("result_held", 64'(bus.result), 64'(e[W-1:0]));
    endtask

    task automatic reset_mid_op();
        @(negedge clk);
        bus.start = 1'b1; bus.opcode = 4'b0010; bus.a = 8'h7F; bus.b = 8'h01;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        // cycle 5: reset together with a competing request
        rst = 1'b1;
        bus.start = 1'b1; bus.a = 8'h11; bus.b = 8'h22;
        @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_result", 64'(bus.result), 64'd0);
        check("rst_overflow", 64'(bus.overflow), 64'd0);
        rst = 1'b0;
        bus.start = 1'b0;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         ovf;
    } vec_t;

    vec_t vecs[9] = '{
        '{4'b0010, 8'h7F, 8'h01, 8'h80, 1'b1},
        '{4'b0110, 8'h05, 8'h07, 8'hFE, 1'b0},
        '{4'b0110, 8'h80, 8'h01, 8'h7F, 1'b1},
        '{4'b0111, 8'h80, 8'h01, 8'h01, 1'b0},
        '{4'b0111, 8'h7F, 8'h80, 8'h00, 1'b0},
        '{4'b0111, 8'h33, 8'h33, 8'h00, 1'b0},
        '{4'b1100, 8'hF0, 8'h0F, 8'h00, 1'b0},
        '{4'b0000, 8'hF0, 8'h3C, 8'h30, 1'b0},
        '{4'b0001, 8'hF0, 8'h3C, 8'hFC, 1'b0}
    };

    initial begin
        logic [W+1:0] m;
        rst = 1'b1;
        bus.start = 1'b0; bus.opcode = '0; bus.a = '0; bus.b = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_result", 64'(bus.result), 64'd0);
        check("reset_overflow", 64'(bus.overflow), 64'd0);
`ifdef BIT_SERIAL_ALU_CTRL_ZERO_FLAG_EN
        check("reset_zero", 64'(bus.zero), 64'd0);
`endif
        rst = 1'b0;

        foreach (vecs[k]) begin
            m = model(vecs[k].op, vecs[k].a, vecs[k].b);
            check("model_pin", 64'(m[W:0]), 64'({vecs[k].ovf, vecs[k].res}));
            run_op(vecs[k].op, vecs[k].a, vecs[k].b, 0);
        end

        // requests while busy and during DONE are dropped
        run_op(4'b0010, 8'h12, 8'h34, 4);
        run_op(4'b0110, 8'h40, 8'hC0, W + 1);
        repeat (3) begin
            @(negedge clk);
            check("idle_no_done", 64'(bus.done), 64'd0);
            check("idle_no_busy", 64'(bus.busy), 64'd0);
        end

        // abort an add (preceded by a nonzero, overflowing result)
        run_op(4'b0010, 8'h7F, 8'h01, 0);
        reset_mid_op();
        run_op(4'b0010, 8'h25, 8'h19, 0);

        for (int n = 0; n < 40; n++) begin
            run_op(4'($urandom_range(0, 15)), W'($urandom), W'($urandom),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W + 1)) : 0);
        end

        repeat (2) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bit_serial_alu_ctrl.md
# bit_serial_alu_ctrl

- Area-minimal multi-bit ALU built around a single 1-bit ALU slice.
- A small controller latches two WIDTH-bit operands and an opcode, then drives the slice LSB to MSB, one bit per clock, threading the carry between cycles.
- Assembles the result word and reports signed overflow and set-less-than.
- Sits wherever the team wants full ALU semantics without paying for WIDTH parallel slices.

## Interface
- WIDTH, 32, operand/result width in bits; legal range 2..64.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only in IDLE.
- opcode  in  4  {ainvert, binvert, op[1:0]}; op 00=AND, 01=OR, 10=ADD, 11=SLT.
  - Named encodings: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR.
  - All other codes execute literally per field.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse in DONE.
- result  out  WIDTH  final word; held from DONE until next accepted start.
- overflow  out  1  signed overflow; ADD/SUB only; held like result.

## Operation
- **States:** IDLE, RUN, DONE. Transitions:
  - IDLE→RUN on start.
  - RUN→DONE after bit WIDTH-1 is processed.
  - DONE→IDLE unconditionally.
- **Accept (IDLE with start=1):**
  - Latch a, b, opcode.
  - Clear result shadow; bit counter=0; carry register=binvert.
- **Each RUN cycle, bit i:**
  - x = a[i]^ainvert, y = b[i]^binvert.
  - op 00 → x&y; op 01 → x|y; op 10 → x^y^c.
  - Carry register ← majority(x,y,c) for every op.
- **op 11 (SLT):**
  - Result bits 1..WIDTH-1 are 0.
  - In the MSB cycle, bit 0 ← sumMSB XOR (c_in_MSB XOR c_out_MSB). This is the overflow-corrected signed less-than.
- **Overflow:**
  - op 10: set when carry into MSB ≠ carry out of MSB.
  - All other ops: 0.
- **Ignored requests:** start while busy or in DONE is ignored; latched operands are not disturbed.
- **Arithmetic:** two's complement; carry-out of MSB discarded.

## Timing
- **Reset values:** state=IDLE; busy=0, done=0, result=0, overflow=0; counter=0, carry=0.
- **Latency:** start sampled at edge 0 → busy high cycles 1..WIDTH → done high in cycle WIDTH+1 → IDLE at WIDTH+2.
- **Throughput:** one operation per WIDTH+2 cycles; back-to-back start is accepted only in IDLE.
- **Output update:** result/overflow update on the edge entering DONE and are stable while done=1.
- **Reset mid-operation:** rst in any state wins over start. Next cycle is IDLE with all outputs zeroed; the partial result is discarded.
- **Counter:** $clog2(WIDTH) bits; terminal count WIDTH-1; no wrap past it.

## Configuration
- Macro: BIT_SERIAL_ALU_CTRL_ZERO_FLAG_EN.
- **Defined:**
  - Adds output port zero (1 bit), reset 0.
  - Set in DONE iff the final result == 0; held with result.
  - Tracked serially by OR-accumulating result bits; no WIDTH-wide compare.
- **Undefined:** port and logic absent; all other behaviour identical.

## Test plan
1. **ADD overflow.** WIDTH=8, opcode 0010, a=0x7F, b=0x01, start at cycle 0 → busy cycles 1..8; done cycle 9; result=0x80; overflow=1.
2. **SUB.** opcode 0110, a=0x05, b=0x07 → result=0xFE, overflow=0. Then a=0x80, b=0x01 → result=0x7F, overflow=1.
3. **SLT.** opcode 0111:
   - a=0x80, b=0x01 → result=0x01.
   - a=0x7F, b=0x80 → result=0x00; overflow=0 in both cases.
   - a=b=0x33 → result=0x00.
4. **Logic ops.** NOR (1100) a=0xF0, b=0x0F → 0x00 (zero=1 when macro defined). AND 0xF0&0x3C → 0x30. OR → 0xFC.
5. **Start while busy.** Assert start with new operands in cycle 4 of an ADD → ignored; original result returned in cycle 9; no second done.
6. **Reset mid-operation.** rst in cycle 5 of an ADD → cycle 6: busy=0, done=0, result=0, overflow=0. A fresh start then completes normally with done at +9.
